// File: rtl/ahb_apb3_bridge_param.sv
// AHB-to-APB3 bridge with one outstanding transfer, wait-state/slave-error handling and registered outputs.
// Optional build define APB_TIMEOUT_EN aborts an ACCESS phase that waits TIMEOUT_CYC cycles on Pready.
module ahb_apb3_bridge_param #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SLV     = 4,
    parameter int                SEL_LSB     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                Hclk,
    input  logic                Hreset,
    input  logic [1:0]          Htrans,
    input  logic [ADDR_W-1:0]   Haddr,
    input  logic                Hwrite,
    input  logic [DATA_W-1:0]   Hwdata,
    input  logic                Hreadyin,
    output logic                Hreadyout,
    output logic [1:0]          Hresp,
    output logic [DATA_W-1:0]   Hrdata,
    output logic [NUM_SLV-1:0]  Pselx,
    output logic                Penable,
    output logic                Pwrite,
    output logic [ADDR_W-1:0]   Paddr,
    output logic [DATA_W-1:0]   Pwdata,
    input  logic [DATA_W-1:0]   Prdata,
    input  logic                Pready,
    input  logic                Pslverr
);

    localparam int IDX_W   = $clog2(NUM_SLV);
    localparam int WIN_LSB = SEL_LSB + IDX_W;

    // IDLE wait | LATCH capture wdata | SETUP psel | ACCESS penable | ERR1/ERR2 two-cycle error response
    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_in_win;
    logic               w_timeout;
    logic               w_unused;
    logic [NUM_SLV-1:0] w_sel_onehot;

    logic               r_hreadyout;
    logic [1:0]         r_hresp;
    logic [DATA_W-1:0]  r_hrdata;
    logic [NUM_SLV-1:0] r_pselx;
    logic               r_penable;
    logic               r_pwrite;
    logic [ADDR_W-1:0]  r_paddr;
    logic [DATA_W-1:0]  r_pwdata;
    logic [IDX_W-1:0]   r_idx;

    assign w_accept = (r_state == S_IDLE) && Hreadyin && Htrans[1];
    assign w_in_win = (Haddr[ADDR_W-1:WIN_LSB] == BASE_ADDR[ADDR_W-1:WIN_LSB]);
    assign w_unused = ^{Htrans[0], 32'(TIMEOUT_CYC)};

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge Hclk) begin
        if (Hreset || r_state == S_SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ACCESS && !Pready) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_ACCESS) && !Pready && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_sel_onehot = '0;
        w_sel_onehot[r_idx] = 1'b1;
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_in_win ? S_LATCH : S_ERR1;
                end
            end
            S_LATCH:  w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (Pready) begin
                    w_state_nxt = Pslverr ? S_ERR1 : S_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR1;
                end
            end
            S_ERR1:   w_state_nxt = S_ERR2;
            S_ERR2:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_hrdata    <= '0;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_idx       <= '0;
        end else begin
            r_hreadyout <= !(w_state_nxt == S_LATCH || w_state_nxt == S_SETUP ||
                             w_state_nxt == S_ACCESS || w_state_nxt == S_ERR1);
            r_hresp     <= (w_state_nxt == S_ERR1 || w_state_nxt == S_ERR2) ? 2'b01 : 2'b00;
            r_pselx     <= (w_state_nxt == S_SETUP || w_state_nxt == S_ACCESS) ? w_sel_onehot : '0;
            r_penable   <= (w_state_nxt == S_ACCESS);
            if (w_accept && w_in_win) begin
                r_paddr  <= Haddr;
                r_pwrite <= Hwrite;
                r_idx    <= Haddr[SEL_LSB +: IDX_W];
            end
            if (r_state == S_LATCH && r_pwrite) begin
                r_pwdata <= Hwdata;
            end
            if (r_state == S_ACCESS && Pready && !Pslverr && !r_pwrite) begin
                r_hrdata <= Prdata;
            end
        end
    end

    assign Hreadyout = r_hreadyout;
    assign Hresp     = r_hresp;
    assign Hrdata    = r_hrdata;
    assign Pselx     = r_pselx;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb3_bridge_param.sv
// Directed bench for ahb_apb3_bridge_param: per-cycle vector table plus hand sequences for stall, timeout and reset.
module tb_ahb_apb3_bridge_param;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Hclk = ~Hclk;

    ahb_apb3_bridge_param #(.TIMEOUT_CYC(4)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Haddr(Haddr), .Hwrite(Hwrite),
        .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout), .Hresp(Hresp),
        .Hrdata(Hrdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    typedef struct {
        logic        hreset;
        logic [1:0]  htrans;
        logic        hreadyin;
        logic [31:0] haddr;
        logic        hwrite;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic        rdy;
        logic [1:0]  resp;
        logic [3:0]  psel;
        logic        pen;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
    } vec_t;

    vec_t vt[$];

    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] RD = 32'h1234_5678;

    function automatic void add(logic hreset, logic [1:0] htrans, logic hreadyin, logic [31:0] haddr,
                                logic hwrite, logic [31:0] hwdata, logic [31:0] prdata, logic pready,
                                logic pslverr, logic rdy, logic [1:0] resp, logic [3:0] psel, logic pen,
                                logic pwr, logic [31:0] paddr, logic [31:0] pwdata, logic [31:0] hrdata);
        vec_t v;
        v.hreset = hreset; v.htrans = htrans; v.hreadyin = hreadyin; v.haddr = haddr;
        v.hwrite = hwrite; v.hwdata = hwdata; v.prdata = prdata; v.pready = pready;
        v.pslverr = pslverr; v.rdy = rdy; v.resp = resp; v.psel = psel; v.pen = pen;
        v.pwr = pwr; v.paddr = paddr; v.pwdata = pwdata; v.hrdata = hrdata;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle_inputs();
        Hreset = 1'b0; Htrans = 2'b00; Hreadyin = 1'b1; Haddr = '0; Hwrite = 1'b0;
        Hwdata = '0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        Hreset = 1'b1;

        //   rst tr ri haddr          w  hwdata         prdata         rdy pslv | rdy resp psel pen pw paddr          pwdata         hrdata
        add(1, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 0, 32'h0,          32'h0,         32'h0);
        // write, index 1, zero-wait slave
        add(0, 2, 1, 32'h8000_1004,  1, 32'h0,         32'h0,         0, 0,   0, 0, 4'h0, 0, 1, 32'h8000_1004,  32'h0,         32'h0);
        add(0, 0, 1, 32'h0,          0, DB,            32'h0,         0, 0,   0, 0, 4'h2, 0, 1, 32'h8000_1004,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         1, 0,   0, 0, 4'h2, 1, 1, 32'h8000_1004,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         1, 0,   1, 0, 4'h0, 0, 1, 32'h8000_1004,  DB,            32'h0);
        // read, index 3, two Pready=0 ACCESS cycles, back-to-back accept
        add(0, 2, 1, 32'h8000_3000,  0, 32'h0,         32'h0,         0, 0,   0, 0, 4'h0, 0, 0, 32'h8000_3000,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   0, 0, 4'h8, 0, 0, 32'h8000_3000,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   0, 0, 4'h8, 1, 0, 32'h8000_3000,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         RD,            0, 0,   0, 0, 4'h8, 1, 0, 32'h8000_3000,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         RD,            0, 0,   0, 0, 4'h8, 1, 0, 32'h8000_3000,  DB,            32'h0);
        add(0, 0, 1, 32'h0,          0, 32'h0,         RD,            1, 0,   1, 0, 4'h0, 0, 0, 32'h8000_3000,  DB,            RD);
        // read, index 2, slave error; Hrdata must keep its old value
        add(0, 2, 1, 32'h8000_2000,  0, 32'h0,         32'h0,         0, 0,   0, 0, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   0, 0, 4'h4, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   0, 0, 4'h4, 1, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'hAAAA_5555, 1, 1,   0, 1, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   1, 1, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        // transfer offered during ERR2 is dropped
        add(0, 2, 1, 32'h8000_1000,  1, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        // out-of-window write
        add(0, 2, 1, 32'h4000_0000,  1, 32'h0,         32'h0,         0, 0,   0, 1, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'hCAFE_F00D, 32'h0,         0, 0,   1, 1, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        // BUSY, and NONSEQ with Hreadyin low, are both ignored
        add(0, 1, 1, 32'h8000_1000,  1, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        add(0, 2, 0, 32'h8000_1000,  1, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 0, 32'h8000_2000,  DB,            RD);
        // SEQ write, index 0
        add(0, 3, 1, 32'h8000_0008,  1, 32'h0,         32'h0,         0, 0,   0, 0, 4'h0, 0, 1, 32'h8000_0008,  DB,            RD);
        add(0, 0, 1, 32'h0,          0, 32'h0000_0001, 32'h0,         0, 0,   0, 0, 4'h1, 0, 1, 32'h8000_0008,  32'h1,         RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         1, 0,   0, 0, 4'h1, 1, 1, 32'h8000_0008,  32'h1,         RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         1, 0,   1, 0, 4'h0, 0, 1, 32'h8000_0008,  32'h1,         RD);
        // just above the window (bit 14 set) is out of range
        add(0, 2, 1, 32'h8000_4000,  0, 32'h0,         32'h0,         0, 0,   0, 1, 4'h0, 0, 1, 32'h8000_0008,  32'h1,         RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   1, 1, 4'h0, 0, 1, 32'h8000_0008,  32'h1,         RD);
        add(0, 0, 1, 32'h0,          0, 32'h0,         32'h0,         0, 0,   1, 0, 4'h0, 0, 1, 32'h8000_0008,  32'h1,         RD);

        for (int i = 0; i < vt.size(); i++) begin
            Hreset = vt[i].hreset; Htrans = vt[i].htrans; Hreadyin = vt[i].hreadyin;
            Haddr = vt[i].haddr; Hwrite = vt[i].hwrite; Hwdata = vt[i].hwdata;
            Prdata = vt[i].prdata; Pready = vt[i].pready; Pslverr = vt[i].pslverr;
            step();
            chk($sformatf("vec%0d {rdy,resp,psel,pen,pwr,paddr,pwdata,hrdata}", i),
                128'({Hreadyout, Hresp, Pselx, Penable, Pwrite, Paddr, Pwdata, Hrdata}),
                128'({vt[i].rdy, vt[i].resp, vt[i].psel, vt[i].pen, vt[i].pwr,
                      vt[i].paddr, vt[i].pwdata, vt[i].hrdata}));
        end

        // Pready stuck low on a read to index 1
        idle_inputs();
        Htrans = 2'b10; Haddr = 32'h8000_1000; Hwrite = 1'b0;
        step();
        idle_inputs();
        step();
        step();
        chk("stall_access_entry {psel,pen,rdy}", 128'({Pselx, Penable, Hreadyout}), 128'({4'h2, 1'b1, 1'b0}));
`ifdef APB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) step();
        chk("timeout_last_access {psel,pen,rdy,resp}", 128'({Pselx, Penable, Hreadyout, Hresp}),
            128'({4'h2, 1'b1, 1'b0, 2'b00}));
        step();
        chk("timeout_err1 {psel,pen,rdy,resp}", 128'({Pselx, Penable, Hreadyout, Hresp}),
            128'({4'h0, 1'b0, 1'b0, 2'b01}));
        step();
        chk("timeout_err2 {rdy,resp}", 128'({Hreadyout, Hresp}), 128'({1'b1, 2'b01}));
        step();
        chk("timeout_idle {rdy,resp,hrdata}", 128'({Hreadyout, Hresp, Hrdata}), 128'({1'b1, 2'b00, RD}));
`else
        for (int k = 0; k < 20; k++) step();
        chk("stall_held {psel,pen,rdy,resp}", 128'({Pselx, Penable, Hreadyout, Hresp}),
            128'({4'h2, 1'b1, 1'b0, 2'b00}));
        Pready = 1'b1; Prdata = 32'h0BAD_F00D;
        step();
        idle_inputs();
        chk("stall_release {psel,pen,rdy,resp,hrdata}", 128'({Pselx, Penable, Hreadyout, Hresp, Hrdata}),
            128'({4'h0, 1'b0, 1'b1, 2'b00, 32'h0BAD_F00D}));
`endif

        // reset asserted while ACCESS waits on Pready
        idle_inputs();
        Htrans = 2'b10; Haddr = 32'h8000_2000; Hwrite = 1'b0;
        step();
        idle_inputs();
        step();
        step();
        step();
        chk("rst_pre {psel,pen,rdy}", 128'({Pselx, Penable, Hreadyout}), 128'({4'h4, 1'b1, 1'b0}));
        Hreset = 1'b1;
        step();
        chk("rst_abort {psel,pen,rdy,resp,paddr,hrdata}",
            128'({Pselx, Penable, Hreadyout, Hresp, Paddr, Hrdata}),
            128'({4'h0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0}));
        Hreset = 1'b0;
        step();
        step();
        chk("rst_after {psel,pen,rdy,resp}", 128'({Pselx, Penable, Hreadyout, Hresp}),
            128'({4'h0, 1'b0, 1'b1, 2'b00}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_apb3_bridge_param.md
Name: ahb_apb3_bridge_param

Overview:
Next-generation AHB-to-APB bridge with parametrised address/data width and slave count. Adds APB3 wait-state (Pready) and slave-error (Pslverr) handling, out-of-range address error response, and registered read data. Sits between the AHB interconnect and the APB peripheral cluster; single FSM, no write buffering (one outstanding transfer).

Parameters:
ADDR_W, 32, address width of Haddr/Paddr
DATA_W, 32, data width of Hwdata/Hrdata/Pwdata/Prdata
NUM_SLV, 4, number of APB slaves (one Pselx bit each), power of 2, 2..16
SEL_LSB, 12, lowest Haddr bit of slave index; IDX_W = clog2(NUM_SLV)
BASE_ADDR, 32'h8000_0000, bridge window base; bits below SEL_LSB+IDX_W ignored
TIMEOUT_CYC, 255, ACCESS-phase timeout (used only with APB_TIMEOUT_EN)

Ports:
Hclk  in  1  clock, all logic on rising edge
Hreset  in  1  synchronous, active-high reset
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Haddr  in  ADDR_W  AHB address
Hwrite  in  1  1=write
Hwdata  in  DATA_W  AHB write data (data phase)
Hreadyin  in  1  AHB bus ready
Hreadyout  out  1  bridge ready
Hresp  out  2  00 OKAY, 01 ERROR
Hrdata  out  DATA_W  registered read data
Pselx  out  NUM_SLV  one-hot APB select
Penable  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata  in  DATA_W  APB read data
Pready  in  1  APB3 ready
Pslverr  in  1  APB3 slave error

Behaviour:
- Reset (Hreset=1 at edge): state IDLE; Hreadyout=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0. Reset mid-transfer aborts at that edge; Pselx/Penable low next cycle, no response completes.
- Accept: in IDLE with Hreadyin=1, Htrans[1]=1. In-window (Haddr[ADDR_W-1:SEL_LSB+IDX_W]==BASE_ADDR same bits) -> latch Haddr, Hwrite, index=Haddr[SEL_LSB+:IDX_W]; go LATCH. Out-of-window -> ERR1. Htrans IDLE/BUSY -> stay IDLE, OKAY, zero wait.
- States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- LATCH: Hreadyout=0; capture Hwdata into Pwdata (writes); -> SETUP.
- SETUP: Pselx[index]=1, Penable=0, Paddr/Pwrite valid; Hreadyout=0; -> ACCESS.
- ACCESS: Penable=1, Pselx held; hold while Pready=0. Pready=1 & Pslverr=0: reads register Prdata into Hrdata; -> IDLE with Hreadyout=1, Hresp=00 next cycle. Pready=1 & Pslverr=1 -> ERR1 (Hrdata unchanged).
- ERR1: Pselx=0, Penable=0, Hresp=01, Hreadyout=0; -> ERR2. ERR2: Hresp=01, Hreadyout=1; -> IDLE (Hresp=00). ERR2 does not accept a new transfer; pipelined transfer is dropped per AHB error rule.
- Latency, zero-wait slave: accept at T, LATCH T+1, SETUP T+2, ACCESS T+3 (Pready=1), Hreadyout=1 at T+4; each Pready=0 cycle adds one. Back-to-back accept allowed in the Hreadyout=1 cycle.
- Paddr = full latched Haddr; Pselx always one-hot or zero; all outputs registered.

Optional Feature:
APB_TIMEOUT_EN: defined -> counter clears on SETUP entry, increments each ACCESS cycle with Pready=0; reaching TIMEOUT_CYC aborts (Pselx/Penable drop) and enters ERR1. Undefined -> no counter; ACCESS waits on Pready indefinitely.

Test Plan:
- Write 0x8000_1004 (index 1), Hwdata=0xDEAD_BEEF, Pready=1 -> Pselx=0010, Paddr=0x8000_1004, Pwdata=0xDEAD_BEEF, Pwrite=1; Hreadyout low 3 cycles, Hresp=00.
- Read 0x8000_3000, Prdata=0x1234_5678, Pready low 2 ACCESS cycles -> Pselx=1000, Penable held 3 cycles, Hrdata=0x1234_5678 with Hreadyout=1, 5 wait states.
- Read 0x8000_2000, Pslverr=1 -> Hresp=01 two cycles, Hreadyout 0 then 1, Hrdata unchanged.
- Write 0x4000_0000 (out of window) -> no Pselx, Hresp=01 two cycles, Hreadyout 0 then 1.
- Hreset=1 during ACCESS (Pready=0) -> next cycle Pselx=0, Penable=0, Hreadyout=1, Hresp=00.
- APB_TIMEOUT_EN, TIMEOUT_CYC=4, Pready stuck 0 -> abort after 4 ACCESS cycles, Hresp=01 two cycles.
